// File: rtl/ack_bus_rr_scheduler.sv
// ack_bus_rr_scheduler: round-robin grant of the shared open-drain ack bus with hold window and release gap
module ack_bus_rr_scheduler #(
  parameter int         ACK_HOLD = 2,
  parameter logic [1:0] IDLE_ID  = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ack_valid_from_modules,
  input  logic [7:0] module_source_ids,
  output logic [3:0] ack_ready_to_module,
  output logic       ack_valid_n,
  output logic [1:0] winner_source_id,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t     state, state_nx;
  logic [1:0] rr_ptr, rr_nx, gnt, gnt_nx, pick;
  logic [3:0] hold_cnt, hold_nx, ready_nx;
  logic [1:0] winner_nx;
  logic       valid_n_nx, busy_nx, found;
  // first asserted request scanning upward from rr_ptr with wrap
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && ack_valid_from_modules[rr_ptr + 2'(k)]) begin
        pick  = rr_ptr + 2'(k);
        found = 1'b1;
      end
    end
  end
  // next state and next registered outputs; idle values unless a branch overrides
  always_comb begin
    state_nx   = state;
    rr_nx      = rr_ptr;
    gnt_nx     = gnt;
    hold_nx    = hold_cnt;
    ready_nx   = 4'b0000;
    valid_n_nx = 1'b1;
    winner_nx  = IDLE_ID;
    busy_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx   = HOLD;
          gnt_nx     = pick;
          hold_nx    = 4'(ACK_HOLD - 1);
          ready_nx   = 4'b0001 << pick;
          valid_n_nx = 1'b0;
          winner_nx  = module_source_ids[2*pick +: 2];
          busy_nx    = 1'b1;
        end
      end
      HOLD: begin
        busy_nx = 1'b1;
        if (hold_cnt == 4'd0) begin
          state_nx = GAP;
          rr_nx    = gnt + 2'd1;
        end else begin
          hold_nx    = hold_cnt - 4'd1;
          valid_n_nx = 1'b0;
          winner_nx  = winner_source_id;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      rr_ptr              <= 2'd0;
      gnt                 <= 2'd0;
      hold_cnt            <= 4'd0;
      ack_ready_to_module <= 4'b0000;
      ack_valid_n         <= 1'b1;
      winner_source_id    <= IDLE_ID;
      busy                <= 1'b0;
    end else begin
      state               <= state_nx;
      rr_ptr              <= rr_nx;
      gnt                 <= gnt_nx;
      hold_cnt            <= hold_nx;
      ack_ready_to_module <= ready_nx;
      ack_valid_n         <= valid_n_nx;
      winner_source_id    <= winner_nx;
      busy                <= busy_nx;
    end
  end
endmodule
